// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor
// Watches the SDRAM command bus during power-up and checks the JEDEC-style
// initialisation sequence: power-up NOP time, PRECHARGE ALL, the AUTO REFRESH
// burst, LOAD MODE with a legal mode word, and the mode-register settle time.
//
// Ports
//   iclk, ireset      clock, asynchronous active-high reset
//   DRAM_CKE          clock enable; the bus is ignored while low
//   DRAM_CS_N .. _WE_N command strobes
//   DRAM_ADDR, DRAM_BA address and bank at command time
//   oready            init sequence accepted (held until reset)
//   oerr, oerr_code   sticky violation flag and code of the first violation
//   omode_reg         address word captured at LOAD MODE
//   orefresh_cnt      AUTO REFRESH commands accepted (saturates at 15)
//
// Error codes
//   1 command before power-up time   2 PRECHARGE without A10 (not ALL)
//   3 first REFRESH inside tRP       4 REFRESH/LOAD MODE inside tRC
//   5 out-of-order command           6 illegal mode word
//   7 command inside tMRD
module sdram_init_monitor #(
   parameter int unsigned T_POWERUP = 20000,
   parameter int unsigned T_RP      = 3,
   parameter int unsigned T_RC      = 9,
   parameter int unsigned T_MRD     = 2,
   parameter int unsigned N_REFRESH = 2
) (
   input  logic        iclk,
   input  logic        ireset,
   input  logic        DRAM_CKE,
   input  logic        DRAM_CS_N,
   input  logic        DRAM_RAS_N,
   input  logic        DRAM_CAS_N,
   input  logic        DRAM_WE_N,
   input  logic [12:0] DRAM_ADDR,
   input  logic [1:0]  DRAM_BA,
   output logic        oready,
   output logic        oerr,
   output logic [2:0]  oerr_code,
   output logic [12:0] omode_reg,
   output logic [3:0]  orefresh_cnt
);

   // Gap counter is wide enough for the power-up time, and never below 15 bits.
   localparam int unsigned PWR_W = $clog2(T_POWERUP + 1);
   localparam int unsigned GAP_W = (PWR_W > 15) ? PWR_W : 15;

   localparam logic [GAP_W-1:0] POWERUP_G = GAP_W'(T_POWERUP);
   localparam logic [GAP_W-1:0] RP_G      = GAP_W'(T_RP);
   localparam logic [GAP_W-1:0] RC_G      = GAP_W'(T_RC);
   localparam logic [GAP_W-1:0] MRD_G     = GAP_W'(T_MRD);
   localparam logic [3:0]       NREF_C    = 4'(N_REFRESH);

   typedef enum logic [2:0] {
      S_PWRUP, S_WAIT_PRE, S_REFRESH, S_MRD, S_READY, S_ERROR
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_PRE, C_REF, C_LMR, C_OTHER
   } cmd_t;

   state_t           state;
   cmd_t             cmd;
   logic [GAP_W-1:0] gap;
   logic [GAP_W-1:0] gap_inc;
   logic             mode_bad;

   // Command decode from the strobes; a deselected chip is a NOP.
   always_comb begin
      cmd = C_OTHER;
      if (DRAM_CS_N) begin
         cmd = C_NOP;
      end else begin
         unique case ({DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N})
            3'b111:  cmd = C_NOP;
            3'b010:  cmd = C_PRE;
            3'b001:  cmd = C_REF;
            3'b000:  cmd = C_LMR;
            default: cmd = C_OTHER;
         endcase
      end
   end

   // Saturating increment of the NOP gap.
   always_comb begin
      gap_inc = gap;
      if (gap != {GAP_W{1'b1}}) gap_inc = gap + GAP_W'(1);
   end

   // Mode word must target BA=0, have a zero operating mode and CL of 2 or 3.
   always_comb begin
      mode_bad = (DRAM_BA != 2'b00) || (DRAM_ADDR[8:7] != 2'b00) ||
                 ((DRAM_ADDR[6:4] != 3'd2) && (DRAM_ADDR[6:4] != 3'd3));
   end

   // Sequence checker; nothing is decoded or counted while CKE is low.
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state        <= S_PWRUP;
         gap          <= '0;
         oready       <= 1'b0;
         oerr         <= 1'b0;
         oerr_code    <= 3'd0;
         omode_reg    <= 13'd0;
         orefresh_cnt <= 4'd0;
      end else if (DRAM_CKE) begin
         gap <= (cmd == C_NOP) ? gap_inc : '0;

         unique case (state)
            S_PWRUP: begin
               if (cmd != C_NOP) begin
                  state     <= S_ERROR;
                  oerr      <= 1'b1;
                  oerr_code <= 3'd1;
               end else if (gap_inc >= POWERUP_G) begin
                  state <= S_WAIT_PRE;
               end
            end

            S_WAIT_PRE: begin
               if (cmd == C_PRE) begin
                  if (DRAM_ADDR[10]) begin
                     state <= S_REFRESH;
                  end else begin
                     state     <= S_ERROR;
                     oerr      <= 1'b1;
                     oerr_code <= 3'd2;
                  end
               end else if (cmd != C_NOP) begin
                  state     <= S_ERROR;
                  oerr      <= 1'b1;
                  oerr_code <= 3'd5;
               end
            end

            S_REFRESH: begin
               unique case (cmd)
                  C_NOP: ;
                  // First refresh is timed from PRECHARGE, later ones from the previous refresh.
                  C_REF: begin
                     if ((orefresh_cnt == 4'd0) && (gap < RP_G)) begin
                        state     <= S_ERROR;
                        oerr      <= 1'b1;
                        oerr_code <= 3'd3;
                     end else if ((orefresh_cnt != 4'd0) && (gap < RC_G)) begin
                        state     <= S_ERROR;
                        oerr      <= 1'b1;
                        oerr_code <= 3'd4;
                     end else if (orefresh_cnt != 4'd15) begin
                        orefresh_cnt <= orefresh_cnt + 4'd1;
                     end
                  end
                  // Timing outranks ordering, which outranks the mode-word check.
                  C_LMR: begin
                     if (gap < RC_G) begin
                        state     <= S_ERROR;
                        oerr      <= 1'b1;
                        oerr_code <= 3'd4;
                     end else if (orefresh_cnt < NREF_C) begin
                        state     <= S_ERROR;
                        oerr      <= 1'b1;
                        oerr_code <= 3'd5;
                     end else if (mode_bad) begin
                        state     <= S_ERROR;
                        oerr      <= 1'b1;
                        oerr_code <= 3'd6;
                     end else begin
                        omode_reg <= DRAM_ADDR;
                        state     <= S_MRD;
                     end
                  end
                  default: begin
                     state     <= S_ERROR;
                     oerr      <= 1'b1;
                     oerr_code <= 3'd5;
                  end
               endcase
            end

            S_MRD: begin
               if (cmd != C_NOP) begin
                  state     <= S_ERROR;
                  oerr      <= 1'b1;
                  oerr_code <= 3'd7;
               end else if (gap_inc >= MRD_G) begin
                  state  <= S_READY;
                  oready <= 1'b1;
               end
            end

            // Terminal states: outputs hold until reset.
            S_READY: ;
            S_ERROR: ;
            default: state <= S_ERROR;
         endcase
      end
   end

endmodule

// File: doc/sdram_init_monitor.md
SDRAM_INIT_MONITOR -- requirements
Module: sdram_init_monitor

Interface
REQ-001 SHALL have parameter T_POWERUP, 20000, minimum CKE-high NOP cycles before the first command (100 us at 200 MHz).
REQ-002 SHALL have parameter T_RP, 3, minimum cycles from PRECHARGE to the next command.
REQ-003 SHALL have parameter T_RC, 9, minimum cycles from AUTO REFRESH to the next command.
REQ-004 SHALL have parameter T_MRD, 2, minimum cycles from LOAD MODE to ready.
REQ-005 SHALL have parameter N_REFRESH, 2, minimum AUTO REFRESH count before LOAD MODE.
REQ-006 SHALL have one clock and one reset; reset is asynchronous and active-high: iclk input 1 clock; ireset input 1 async active-high reset.
REQ-007 SHALL have inputs: DRAM_CKE 1 clock enable; DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N 1 each command strobes; DRAM_ADDR 13 address; DRAM_BA 2 bank.
REQ-008 SHALL have outputs: oready 1 init sequence accepted; oerr 1 sticky violation flag; oerr_code 3 first-violation code; omode_reg 13 captured mode register; orefresh_cnt 4 refreshes seen.

Function
REQ-009 SHALL sample the bus on iclk rising edge only when DRAM_CKE=1; with CKE=0 no command is decoded and no timing counter advances.
REQ-010 SHALL decode {CS_N,RAS_N,CAS_N,WE_N}: CS_N=1 or 0111 NOP; 0010 PRECHARGE; 0001 AUTO REFRESH; 0000 LOAD MODE; all other codes OTHER.
REQ-011 SHALL hold a gap counter: cleared on every non-NOP command, +1 per CKE-high cycle otherwise, saturating at its width maximum (at least 15 bits).
REQ-012 SHALL implement states PWRUP, WAIT_PRE, REFRESH, MRD, READY, ERROR.
REQ-013 PWRUP: non-NOP command with gap < T_POWERUP -> ERROR code 1; gap reaching T_POWERUP -> WAIT_PRE.
REQ-014 WAIT_PRE: NOP stays; PRECHARGE with ADDR[10]=1 -> REFRESH; PRECHARGE with ADDR[10]=0 -> ERROR code 2; any other command -> ERROR code 5.
REQ-015 REFRESH: AUTO REFRESH with gap < T_RP (first) or < T_RC (later) -> ERROR code 3 or 4 respectively; otherwise orefresh_cnt +1, saturating at 15.
REQ-016 REFRESH: LOAD MODE with orefresh_cnt < N_REFRESH -> ERROR code 5; with gap < T_RC -> ERROR code 4; with BA!=0, ADDR[8:7]!=0 or ADDR[6:4] not 2 or 3 -> ERROR code 6; else capture ADDR into omode_reg and -> MRD.
REQ-017 REFRESH: PRECHARGE or OTHER -> ERROR code 5.
REQ-018 MRD: non-NOP with gap < T_MRD -> ERROR code 7; gap reaching T_MRD -> READY.
REQ-019 READY: oready=1 one cycle after the T_MRD-th NOP, held until reset; later commands ignored.
REQ-020 ERROR: terminal; oerr=1 and oerr_code registered in the cycle after the violating command, held until reset; oready=0.
REQ-021 When one command violates several rules, the priority SHALL be code order 3/4 before 5 before 6 (timing first).
REQ-022 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-023 ireset=1 SHALL asynchronously force PWRUP, gap=0, oready=0, oerr=0, oerr_code=0, omode_reg=0, orefresh_cnt=0.
REQ-024 Reset asserted mid-sequence SHALL discard all progress; monitoring restarts at PWRUP after release.

Verification (T_POWERUP=100, T_RP=3, T_RC=9, T_MRD=2, N_REFRESH=2)
REQ-025 100 NOPs, PRECHARGE A10=1, 3 NOP, REFRESH, 9 NOP, REFRESH, 9 NOP, LOAD MODE ADDR=0x022, 2 NOP -> oready=1, omode_reg=0x022, orefresh_cnt=2, oerr=0.
REQ-026 PRECHARGE after 50 NOPs -> oerr=1, oerr_code=1, oready=0.
REQ-027 Legal start, second REFRESH 4 cycles after first -> oerr_code=4; later traffic leaves code unchanged.
REQ-028 Legal sequence with only one REFRESH before LOAD MODE -> oerr_code=5; LOAD MODE ADDR=0x052 (CL=5) after two refreshes -> oerr_code=6.
REQ-029 CKE=0 for 40 cycles inside PWRUP then 100 NOPs -> no error, gap counter frozen during CKE=0.
REQ-030 ireset pulse during REFRESH with orefresh_cnt=1 -> all outputs 0 immediately; full legal sequence afterwards reaches oready=1.
